// File: rtl/mux_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin arbitrated mux:
//   - state_e         : arbiter FSM states (IDLE, GRANT)
//   - N_DEFAULT       : default number of requesters / mux inputs (8)
//   - SEL_W_DEFAULT   : default select width, clog2(N_DEFAULT) (3)
//   - onehot_to_idx() : converts a one-hot grant vector to its binary index
// ----------------------------------------------------------------------------
package mux_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int N_DEFAULT     = 8;
   localparam int SEL_W_DEFAULT = 3;

   // OR-reduces the indices of all set bits; exact for a one-hot input,
   // and yields 0 for an all-zero input.
   function automatic logic [SEL_W_DEFAULT-1:0] onehot_to_idx(
      input logic [N_DEFAULT-1:0] oh
   );
      logic [SEL_W_DEFAULT-1:0] idx;
      idx = {SEL_W_DEFAULT{1'b0}};
      for (int i = 0; i < N_DEFAULT; i++) begin
         idx = idx | (oh[i] ? SEL_W_DEFAULT'(i) : {SEL_W_DEFAULT{1'b0}});
      end
      return idx;
   endfunction

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder: returns the first asserted request found
// scanning upward from ptr+1, wrapping modulo N.
// Ports:
//   req [N]     : request vector
//   ptr [SEL_W] : index served last (search starts just above it)
//   any         : 1 when at least one request is asserted
//   idx [SEL_W] : winning index (equals ptr when any is 0)
// ----------------------------------------------------------------------------
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int SEL_W = SEL_W_DEFAULT
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   // Scan from the farthest candidate (ptr+N) down to the nearest (ptr+1) so
   // the nearest asserted request is the last one written and therefore wins.
   always_comb begin
      int cand;
      any  = 1'b0;
      idx  = ptr;
      cand = 0;
      for (int k = N; k >= 1; k--) begin
         cand = (int'(ptr) + k) % N;
         any  = any | req[cand];
         idx  = req[cand] ? SEL_W'(cand) : idx;
      end
   end

endmodule : rr_pick

// File: rtl/mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter driving an N:1 single-bit data mux. A granted requester
// offers one transfer (out_valid) which completes when out_ready is high at a
// rising edge; the next winner is granted at that same edge.
// Ports:
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   req [N]    : level-sensitive requests
//   in  [N]    : data bit per requester
//   out_ready  : consumer accepts the offered transfer
//   grant [N]  : registered one-hot grant (zero when idle)
//   sel [SEL_W]: registered index of the granted requester
//   out_valid  : registered transfer-offered flag
//   y          : in[sel] while out_valid, else 0 (combinational)
// Configuration:
//   MUX_ARB_BURST_EN : when defined, a requester keeps the grant while its
//                      request stays high, for up to HOLD_MAX transfers.
// ----------------------------------------------------------------------------
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N        = N_DEFAULT,
   parameter int SEL_W    = SEL_W_DEFAULT,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     in,
   input  logic             out_ready,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] sel,
   output logic             out_valid,
   output logic             y
);

   if ((N != 8) || (SEL_W != 3) || (HOLD_MAX < 1) || (HOLD_MAX > 15)) begin : g_param_check
      $error("mux_rr_arbiter: unsupported parameter set");
   end

   state_e           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic [SEL_W-1:0] ptr_q,   ptr_d;
   logic             valid_q, valid_d;
   // Low for the first edge after reset release so no grant lands on it.
   logic             armed_q, armed_d;

   logic             keep_s;
   logic [SEL_W-1:0] pick_ptr_s;
   logic             pick_any_s;
   logic [SEL_W-1:0] pick_idx_s;

   // While granted, ptr is about to become sel, so search from sel directly.
   assign pick_ptr_s = (state_q == GRANT) ? sel_q : ptr_q;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req (req),
      .ptr (pick_ptr_s),
      .any (pick_any_s),
      .idx (pick_idx_s)
   );

`ifdef MUX_ARB_BURST_EN
   localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);
   logic [3:0] hold_q, hold_d;

   // Burst continuation: stay on sel while it still requests and the burst
   // has not yet reached HOLD_MAX completed transfers.
   always_comb begin
      keep_s = req[sel_q] && ((hold_q + 4'd1) < HOLD_LIMIT);
   end

   // Hold counter counts completed transfers of the current burst.
   always_comb begin
      hold_d = hold_q;
      if ((state_q == GRANT) && out_ready) begin
         hold_d = keep_s ? (hold_q + 4'd1) : 4'd0;
      end else begin
         hold_d = hold_q;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 4'd0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   // One transfer per grant: always rotate after a completion.
   always_comb begin
      keep_s = 1'b0;
   end
`endif

   // Next-state and next-output logic for the arbiter FSM.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      armed_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (armed_q && pick_any_s) begin
               state_d = GRANT;
               grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
               sel_d   = onehot_to_idx(grant_d);
               valid_d = 1'b1;
            end else begin
               grant_d = {N{1'b0}};
               valid_d = 1'b0;
            end
         end
         GRANT: begin
            if (out_ready) begin
               ptr_d = sel_q;
               if (keep_s) begin
                  grant_d = grant_q;
               end else if (pick_any_s) begin
                  grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
                  sel_d   = onehot_to_idx(grant_d);
                  valid_d = 1'b1;
               end else begin
                  // Nothing pending: drop to IDLE, sel keeps its last value.
                  state_d = IDLE;
                  grant_d = {N{1'b0}};
                  valid_d = 1'b0;
               end
            end else begin
               // Offered transfer is held stable until accepted.
               grant_d = grant_q;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = {N{1'b0}};
            valid_d = 1'b0;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= {N{1'b0}};
         sel_q   <= {SEL_W{1'b0}};
         ptr_q   <= SEL_W'(N - 1);
         valid_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         armed_q <= armed_d;
      end
   end

   assign grant     = grant_q;
   assign sel       = sel_q;
   assign out_valid = valid_q;
   assign y         = valid_q ? in[sel_q] : 1'b0;

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter: a transaction-level model tracks the
// granted index, last-served index and burst length; a compare process checks
// grant/sel/out_valid/y every cycle, and directed scenarios pin the model with
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

   localparam int N        = 8;
   localparam int SEL_W    = 3;
   localparam int HOLD_MAX = 4;
`ifdef MUX_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req = 8'h00;
   logic [N-1:0]     in = 8'h00;
   logic             out_ready = 1'b0;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] sel;
   logic             out_valid;
   logic             y;

   int checks   = 0;
   int failures = 0;

   mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in        (in),
      .out_ready (out_ready),
      .grant     (grant),
      .sel       (sel),
      .out_valid (out_valid),
      .y         (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_valid;
   int m_sel;
   int m_last;
   int m_served;
   bit m_armed;

   function automatic int winner(input logic [N-1:0] r, input int from);
      for (int k = 1; k <= N; k++) begin
         if (r[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  = 1'b0;
         m_sel    = 0;
         m_last   = N - 1;
         m_served = 0;
         m_armed  = 1'b0;
      end else begin
         if (!m_valid) begin
            if (m_armed && (req != 8'h00)) begin
               m_sel   = winner(req, m_last);
               m_valid = 1'b1;
            end
         end else if (out_ready) begin
            m_last = m_sel;
            m_served++;
            if (!(BURST && req[m_sel] && (m_served < HOLD_MAX))) begin
               m_served = 0;
               if (req != 8'h00) m_sel = winner(req, m_last);
               else m_valid = 1'b0;
            end
         end
         m_armed = 1'b1;
      end
   end

   // Per-cycle compare against the model (outputs change only at posedge).
   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_grant", 32'(grant), m_valid ? (32'd1 << m_sel) : 32'd0);
         check("cmp_sel", 32'(sel), 32'(m_sel));
         check("cmp_valid", 32'(out_valid), 32'(m_valid));
         check("cmp_y", 32'(y), m_valid ? 32'(in[m_sel]) : 32'd0);
      end
   end

   // Advance one cycle; returns at negedge+1 with fresh outputs.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Reset pulse released away from clock edges, then one arming cycle.
   task automatic do_reset();
      req       = 8'h00;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #20;
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      int cnt;
      int exp36 [9] = '{0, 0, 0, 0, 3, 3, 3, 3, 0};

      // Reset state
      #11;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);

      // Single requester 0: no grant on the first edge, then back-to-back.
      req = 8'b0000_0001; out_ready = 1'b1; in = 8'h01;
      rst_n = 1'b1;
      cyc();
      check("first_edge_no_grant", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("single_grant", 32'(grant), 32'h01);
         check("single_sel", 32'(sel), 32'd0);
         check("single_valid", 32'(out_valid), 32'd1);
      end

      // All requesting: rotation 0..7,0 (HOLD_MAX repeats each in burst mode).
      do_reset();
      req = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         check("rr_seq", 32'(sel), BURST ? 32'((i / HOLD_MAX) % N) : 32'(i % N));
      end

      // Stall at sel=2 for 3 cycles.
      do_reset();
      in = 8'b0111_0101; req = 8'hFF; out_ready = 1'b1;
      cnt = 0;
      cyc();
      while (!(out_valid && (sel == 3'd2)) && (cnt < 20)) begin
         cyc();
         cnt++;
      end
      check("reach_sel2_in_budget", 32'(cnt < 20), 32'd1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_sel", 32'(sel), 32'd2);
         check("stall_grant", 32'(grant), 32'h04);
         check("stall_y", 32'(y), 32'd1);
      end
      out_ready = 1'b1;
      cyc();
      check("after_stall_sel", 32'(sel), BURST ? 32'd2 : 32'd3);
      check("after_stall_y", 32'(y), BURST ? 32'd1 : 32'd0);

      // Granted to 5, request drops while stalled.
      do_reset();
      req = 8'b0010_0000; out_ready = 1'b0;
      cyc();
      check("g5_grant", 32'(grant), 32'h20);
      check("g5_sel", 32'(sel), 32'd5);
      req = 8'h00;
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("g5_hold_valid", 32'(out_valid), 32'd1);
         check("g5_hold_sel", 32'(sel), 32'd5);
      end
      out_ready = 1'b1;
      cyc();
      check("g5_idle_valid", 32'(out_valid), 32'd0);
      check("g5_idle_grant", 32'(grant), 32'd0);
      check("g5_idle_sel", 32'(sel), 32'd5);

`ifdef MUX_ARB_BURST_EN
      // Burst with HOLD_MAX=4 on requesters 0 and 3.
      do_reset();
      req = 8'b0000_1001; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         check("burst_seq", 32'(sel), 32'(exp36[i]));
      end
`endif

      // Mixed traffic against the model.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         in        = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         cyc();
      end

      // Asynchronous reset mid-GRANT.
      do_reset();
      req = 8'b0011_0000; out_ready = 1'b0;
      cyc();
      check("pre_async_sel", 32'(sel), 32'd4);
      #2;
      req   = 8'b0001_0100;
      rst_n = 1'b0;
      #1;
      check("async_grant", 32'(grant), 32'd0);
      check("async_valid", 32'(out_valid), 32'd0);
      check("async_sel", 32'(sel), 32'd0);
      check("async_y", 32'(y), 32'd0);
      #13;
      rst_n = 1'b1;
      cnt = 0;
      while (!out_valid && (cnt < 6)) begin
         @(negedge clk);
         cnt++;
      end
      #1;
      check("post_async_in_budget", 32'(cnt < 6), 32'd1);
      check("post_async_latency", 32'(cnt >= 3), 32'd1);
      check("post_async_sel", 32'(sel), 32'd2);
      check("post_async_grant", 32'(grant), 32'h04);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mux_rr_arbiter
